// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types for the MEM-stage load/store unit
// Contents: bus access sizes, LWL/LWR/SWL/SWR mode, unit FSM states,
//           dbus request/response structs, unit request struct, lane shift helper.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic [1:0] {
    LR_NONE  = 2'd0,
    LR_LEFT  = 2'd1,
    LR_RIGHT = 2'd2
  } lr_mode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    FIN   = 3'd3,
    DRAIN = 3'd4
  } mau_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] offset;
    logic        mem_read;
    logic        mem_write;
    msize_t      msize;
    logic        unsign_en;
    lr_mode_t    lr_mode;
    logic [31:0] wdata;
    logic [31:0] rt_old;
  } mau_req_t;

  // Bit distance of byte lane n from lane 0.
  function automatic logic [4:0] lane_shift(input logic [1:0] n);
    return {n, 3'b000};
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// rtl/mem_access_unit_align.sv - combinational store strobe/data and load extract/merge
// Ports: msize, lr_mode, addr_lo (ea[1:0]), wdata, bus_data, rt_old, unsign_en (in);
//        strobe, wdata_aligned, rdata (out).
module mau_align
  import mem_access_unit_pkg::*;
(
  input  msize_t      msize,
  input  lr_mode_t    lr_mode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_data,
  input  logic [31:0] rt_old,
  input  logic        unsign_en,
  output logic [3:0]  strobe,
  output logic [31:0] wdata_aligned,
  output logic [31:0] rdata
);

  logic [4:0]  sh_lo;   // 8*a
  logic [4:0]  sh_hi;   // 8*(3-a)
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    sh_lo = lane_shift(addr_lo);
    sh_hi = lane_shift(2'd3 - addr_lo);
    rbyte = 8'(bus_data >> sh_lo);
    rhalf = addr_lo[1] ? bus_data[31:16] : bus_data[15:0];

    strobe        = 4'b1111;
    wdata_aligned = wdata;
    rdata         = bus_data;

    case (lr_mode)
      LR_LEFT: begin
        strobe        = 4'b1111 >> (2'd3 - addr_lo);
        wdata_aligned = wdata >> sh_hi;
        rdata         = (bus_data << sh_hi) | (rt_old & ~(32'hFFFF_FFFF << sh_hi));
      end
      LR_RIGHT: begin
        strobe        = 4'b1111 << addr_lo;
        wdata_aligned = wdata << sh_lo;
        rdata         = (bus_data >> sh_lo) | (rt_old & ~(32'hFFFF_FFFF >> sh_lo));
      end
      default: begin
        case (msize)
          MSIZE1: begin
            strobe        = 4'b0001 << addr_lo;
            wdata_aligned = {24'b0, wdata[7:0]} << sh_lo;
            rdata         = unsign_en ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
          end
          MSIZE2: begin
            strobe        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_aligned = addr_lo[1] ? {wdata[15:0], 16'b0} : {16'b0, wdata[15:0]};
            rdata         = unsign_en ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
          end
          default: begin
            strobe        = 4'b1111;
            wdata_aligned = wdata;
            rdata         = bus_data;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - sequential MEM-stage load/store unit with address-error detection
// Ports: clk, resetn (async, active-low), start, req, cp0_flush, dresp (in);
//        dreq, mem_halt, done, rdata, AdEL, AdES, BadVAddr (out).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter bit          EN_LR   = 1'b1,
  parameter bit          OUT_REG = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  mau_req_t          req,
  input  logic              cp0_flush,
  output dbus_req_t         dreq,
  input  dbus_resp_t        dresp,
  output logic              mem_halt,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              AdEL,
  output logic              AdES,
  output logic [ADDR_W-1:0] BadVAddr
);

  if (DATA_W != 32 || ADDR_W > 32) begin : g_bad_param
    $error("mem_access_unit: DATA_W must be 32 and ADDR_W at most 32");
  end

  mau_state_t state, state_nxt;

  logic [ADDR_W-1:0] ea;
  logic              is_lr, misalign, fault, accept, raise;
  logic              req_ack, fin_bus, done_bus;

  // Fields frozen for the whole bus transaction.
  logic [ADDR_W-1:0] addr_q;
  msize_t            msize_q;
  lr_mode_t          lr_q;
  logic              unsign_q, write_q;
  logic [31:0]       wdata_q, rt_old_q;

  logic [DATA_W-1:0] rdata_q;
  logic              fault_q, adel_q, ades_q;
  logic [ADDR_W-1:0] badv_q;

  logic [3:0]        al_strobe;
  logic [31:0]       al_wdata, al_rdata;
  logic [ADDR_W-1:0] bus_addr;

  always_comb begin
    ea       = req.base[ADDR_W-1:0] + req.offset[ADDR_W-1:0];
    is_lr    = req.lr_mode != LR_NONE;
    // LR ops are word-aligned on the bus, so their low address bits never fault.
    misalign = !is_lr && ((req.msize == MSIZE4 && ea[1:0] != 2'b00) ||
                          (req.msize == MSIZE2 && ea[0]));
    fault    = misalign || (!EN_LR && is_lr);
    accept   = start && state == IDLE && !fault && !cp0_flush;
    raise    = start && state == IDLE &&  fault && !cp0_flush;

    req_ack  = state == REQ && dresp.addr_ok;
    fin_bus  = (req_ack && dresp.data_ok) || (state == WAIT && dresp.data_ok);
    done_bus = fin_bus && !cp0_flush;
  end

  mau_align u_align (
    .msize         (msize_q),
    .lr_mode       (lr_q),
    .addr_lo       (addr_q[1:0]),
    .wdata         (wdata_q),
    .bus_data      (dresp.data),
    .rt_old        (rt_old_q),
    .unsign_en     (unsign_q),
    .strobe        (al_strobe),
    .wdata_aligned (al_wdata),
    .rdata         (al_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = REQ;
      REQ: begin
        if (cp0_flush) begin
          // Once the address is accepted the response must still be drained.
          if (dresp.addr_ok && !dresp.data_ok) state_nxt = DRAIN;
          else                                 state_nxt = IDLE;
        end else if (dresp.addr_ok) begin
          if (dresp.data_ok) state_nxt = OUT_REG ? FIN : IDLE;
          else               state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (dresp.data_ok) state_nxt = (cp0_flush || !OUT_REG) ? IDLE : FIN;
        else if (cp0_flush) state_nxt = DRAIN;
      end
      FIN:   state_nxt = IDLE;
      DRAIN: if (dresp.data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_addr = (lr_q != LR_NONE) ? {addr_q[ADDR_W-1:2], 2'b00} : addr_q;
    dreq     = '0;
    if (state == REQ) begin
      dreq.valid  = 1'b1;
      dreq.addr   = 32'(bus_addr);
      dreq.size   = msize_q;
      dreq.strobe = write_q ? al_strobe : 4'b0000;
      dreq.data   = write_q ? al_wdata  : 32'b0;
    end
    done     = fault_q || (OUT_REG ? (state == FIN) : done_bus);
    rdata    = (!OUT_REG && done_bus) ? DATA_W'(al_rdata) : rdata_q;
    AdEL     = adel_q;
    AdES     = ades_q;
    BadVAddr = badv_q;
    mem_halt = (state != IDLE && !done) || accept;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q   <= '0;
      msize_q  <= MSIZE1;
      lr_q     <= LR_NONE;
      unsign_q <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      rt_old_q <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
      badv_q   <= '0;
    end else begin
      if (accept) begin
        addr_q   <= ea;
        msize_q  <= is_lr ? MSIZE4 : req.msize;
        lr_q     <= req.lr_mode;
        unsign_q <= req.unsign_en;
        write_q  <= req.mem_write;
        wdata_q  <= req.wdata;
        rt_old_q <= req.rt_old;
      end
      if (done_bus) rdata_q <= DATA_W'(al_rdata);
      fault_q <= raise;
      adel_q  <= raise && req.mem_read;
      ades_q  <= raise && req.mem_write;
      badv_q  <= raise ? ea : '0;
    end
  end

endmodule
